// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state encoding and default timing constants for button_conditioner
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED    = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD        = 3'd2,
        ST_REPEAT      = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES      = 500000;
    localparam int DEF_REPEAT_DELAY_CYCLES  = 25000000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 5000000;
    localparam int DEF_ACTIVE_LOW           = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a configurable reset level
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= RESET_VALUE;
            o_q  <= RESET_VALUE;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced push-button with press/release/auto-repeat pulses
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
    parameter int ACTIVE_LOW           = DEF_ACTIVE_LOW
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_level,
    output logic o_pressPulse,
    output logic o_releasePulse,
    output logic o_repeatPulse,
    output logic o_countUp
);

    localparam int   CNT_MAX      = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam int   CNT_W        = $clog2(CNT_MAX);
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic             sync_q;
    logic             pressed;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, release_nxt, repeat_nxt, level_nxt;

    sync_2ff #(
        .RESET_VALUE(RAW_RELEASED)
    ) u_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_button),
        .o_q  (sync_q)
    );

    assign pressed = sync_q ^ RAW_RELEASED;

    // Every counting state leaves at its terminal value, so cnt + 1 never wraps.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            ST_RELEASED: begin
                cnt_nxt = '0;
                if (pressed) state_nxt = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
                if (!pressed) begin
                    state_nxt = ST_RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_nxt = ST_DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == DELAY_LAST) begin
                    state_nxt  = ST_REPEAT;
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!pressed) begin
                    state_nxt = ST_DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == PERIOD_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end
            end
            ST_DEB_RELEASE: begin
                // A bounce back to pressed restarts the repeat delay without a new press pulse.
                if (pressed) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = ST_RELEASED;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_REPEAT) ||
                    (state_nxt == ST_DEB_RELEASE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_RELEASED;
            cnt            <= '0;
            o_level        <= 1'b0;
            o_pressPulse   <= 1'b0;
            o_releasePulse <= 1'b0;
            o_repeatPulse  <= 1'b0;
            o_countUp      <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            o_level        <= level_nxt;
            o_pressPulse   <= press_nxt;
            o_releasePulse <= release_nxt;
            o_repeatPulse  <= repeat_nxt;
            o_countUp      <= press_nxt | repeat_nxt;
        end
    end

endmodule
